// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one line-wide memory port between the I-cache (read) and D-cache (read/write).
// Latency: a request seen at an IDLE edge drives a registered command next cycle; ready is steered combinationally.
// Backpressure: loser waits with request held; owner completes on mem_ready; one TURN cycle follows each completion.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the D-cache always wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 30,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURN} state_t;

    state_t             state, state_nxt;
    logic               last_d, last_d_nxt;   // 1 when the D-cache was served most recently
    logic               rd_nxt, wr_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [LINE_W-1:0]  wdata_nxt;
    logic               d_req;
    logic               tie_d;                // D wins when both sides request in IDLE

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_d = ~last_d;
`else
    assign tie_d = 1'b1;
`endif

    // Read data goes to both caches; only the ready strobes are steered.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Next-state, next-command and ready steering.
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        rd_nxt     = mem_read;
        wr_nxt     = mem_write;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_read || tie_d)) begin
                    // Read and write together is treated as a write-back.
                    state_nxt = GRANT_D;
                    rd_nxt    = ~d_write;
                    wr_nxt    = d_write;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                end else if (i_read) begin
                    state_nxt = GRANT_I;
                    rd_nxt    = 1'b1;
                    wr_nxt    = 1'b0;
                    addr_nxt  = i_addr;
                    wdata_nxt = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    // Reset abandons the transaction, so no strobe escapes in a reset cycle.
                    i_ready    = (state == GRANT_I) && !proc_reset;
                    d_ready    = (state == GRANT_D) && !proc_reset;
                    last_d_nxt = (state == GRANT_D);
                    state_nxt  = TURN;
                    rd_nxt     = 1'b0;
                    wr_nxt     = 1'b0;
                    addr_nxt   = '0;
                    wdata_nxt  = '0;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, fairness history and registered memory command.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            last_d    <= last_d_nxt;
            mem_read  <= rd_nxt;
            mem_write <= wr_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, checked each cycle
// against a transaction-level model of who owns the memory port and what command it carries.
module tb_mem_arbiter;

    localparam int NONE  = 0;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, d_read, d_write, mem_ready;
    logic [29:0]   i_addr, d_addr;
    logic [127:0]  d_wdata, mem_rdata;
    logic [127:0]  i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [29:0]   mem_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: owner of the port, one-cycle turnaround flag, last side served, expected command.
    int            m_owner;
    bit            m_turn;
    int            m_last;
    logic          e_rd, e_wr;
    logic [29:0]   e_addr;
    logic [127:0]  e_wd;
    int            comp_who[$];
    int            comp_cyc[$];

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit d_wins_tie();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return m_last != OWN_D;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_owner = NONE; m_turn = 0; m_last = OWN_I;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    endfunction

    // One clock cycle: drive at the falling edge, check, advance the model, cross the rising edge.
    task automatic step(input logic rst, input logic ir, input logic dr, input logic dw,
                        input logic [29:0] ia, input logic [29:0] da,
                        input logic [127:0] wd, input logic mr);
        logic [127:0] rdat;
        rdat = {$urandom, $urandom, $urandom, $urandom};
        proc_reset = rst; i_read = ir; d_read = dr; d_write = dw;
        i_addr = ia; d_addr = da; d_wdata = wd; mem_ready = mr; mem_rdata = rdat;
        #1;
        chk("i_ready",   i_ready,   (m_owner == OWN_I) && mr && !rst);
        chk("d_ready",   d_ready,   (m_owner == OWN_D) && mr && !rst);
        chk("mem_read",  mem_read,  e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("i_rdata",   i_rdata,   rdat);
        chk("d_rdata",   d_rdata,   rdat);
        if (rst) begin
            model_reset();
        end else if (m_owner != NONE) begin
            if (mr) begin
                comp_who.push_back(m_owner);
                comp_cyc.push_back(cyc);
                m_last = m_owner; m_owner = NONE; m_turn = 1;
                e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
            end
        end else if (m_turn) begin
            m_turn = 0;
        end else if ((dr || dw) && (!ir || d_wins_tie())) begin
            m_owner = OWN_D; e_rd = !dw; e_wr = dw; e_addr = da; e_wd = wd;
        end else if (ir) begin
            m_owner = OWN_I; e_rd = 1; e_wr = 0; e_addr = ia; e_wd = '0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Lone request held until completion; memory answers lat cycles after the command appears.
    task automatic xact(input logic ir, input logic dr, input logic dw, input logic [29:0] ia,
                        input logic [29:0] da, input logic [127:0] wd, input int lat);
        int  waited;
        bit  done;
        waited = 0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (m_owner != NONE && waited == lat) begin
                step(0, ir, dr, dw, ia, da, wd, 1); done = 1;
            end else begin
                if (m_owner != NONE) waited++;
                step(0, ir, dr, dw, ia, da, wd, 0);
            end
        end
        chk("xact_done", done, 1'b1);
        step(0, ir, dr, dw, ia, da, wd, 0);   // request lingers through the turnaround cycle
        step(0, 0, 0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[3];
        logic [127:0] wb;
        proc_reset = 1; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        @(negedge clk); @(posedge clk); model_reset(); @(negedge clk);

        // Reset held with both sides requesting and memory strobing.
        step(1, 1, 1, 0, 30'h100, 30'h200, '1, 1);
        step(1, 1, 1, 0, 30'h100, 30'h200, '1, 1);
        chk("rst_no_grant", mem_read | mem_write, 1'b0);
        step(0, 0, 0, 0, '0, '0, '0, 0);

        // Lone I-cache read, memory answers 4 cycles after the command.
        comp_who.delete(); comp_cyc.delete();
        xact(1, 0, 0, 30'h0000100, 30'h3, '0, 4);
        chk("lone_i_owner", comp_who.size() == 1 && comp_who[0] == OWN_I, 1'b1);

        // D-cache write-back, then read+write together behaves the same.
        wb = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0};
        xact(0, 0, 1, 30'h5, 30'h0000200, wb, 2);
        xact(0, 1, 1, 30'h5, 30'h0000200, wb, 1);
        xact(0, 1, 0, 30'h5, 30'h0000240, wb, 0);

        // Both sides held continuously from a fresh reset: grant order and completion spacing.
        step(1, 0, 0, 0, '0, '0, '0, 0);
        comp_who.delete(); comp_cyc.delete();
        for (int n = 0; n < 40 && comp_who.size() < 3; n++)
            step(0, 1, 0, 1, 30'h111, 30'h222, 128'hA5, m_owner != NONE);
        chk("both_count", comp_who.size(), 3);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{OWN_D, OWN_I, OWN_D};
`else
        exp_order = '{OWN_D, OWN_D, OWN_D};
`endif
        for (int k = 0; k < 3 && k < comp_who.size(); k++)
            chk($sformatf("order%0d", k), comp_who[k], exp_order[k]);
        for (int k = 1; k < comp_cyc.size(); k++)
            chk($sformatf("spacing%0d", k), (comp_cyc[k] - comp_cyc[k-1]) >= 3, 1'b1);
        step(0, 0, 0, 0, '0, '0, '0, 0);
        step(0, 0, 0, 0, '0, '0, '0, 0);

        // Reset during GRANT_I with memory ready high.
        step(0, 1, 0, 0, 30'h300, '0, '0, 0);
        step(0, 1, 0, 0, 30'h300, '0, '0, 0);
        chk("gi_owner", m_owner, OWN_I);
        step(1, 1, 0, 0, 30'h300, '0, '0, 1);
        step(0, 0, 0, 0, '0, '0, '0, 0);
        chk("post_rst_read", mem_read, 1'b0);
        step(0, 0, 1, 0, '0, 30'h310, '0, 0);
        chk("post_rst_grant", mem_read, 1'b1);
        step(0, 0, 1, 0, '0, 30'h310, '0, 1);

        // Spurious ready in TURN (request lingering) and in IDLE.
        step(0, 0, 1, 0, '0, 30'h310, '0, 1);
        step(0, 0, 0, 0, '0, '0, '0, 1);
        step(0, 0, 0, 0, '0, '0, '0, 1);
        chk("spurious_idle", mem_read | mem_write, 1'b0);

        // Random traffic, including dropped requests and occasional resets.
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), 30'($urandom), 30'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
